// File: rtl/fd_fetch_queue_pkg.sv
// Shared types and reset constants for the fetch/decode instruction queue.
package fd_fetch_queue_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fd_fetch_queue_if.sv
// Fetch-to-decode handshake bundle; master drives fetch/decode requests,
// slave is the queue itself.
interface fd_fetch_queue_if #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
);

    logic [31:0]   F_PC;
    logic [31:0]   F_Instr;
    logic          F_valid;
    logic          F_ready;
    logic          D_flush;
    logic          D_ready;
    logic          D_valid;
    logic [31:0]   D_PC;
    logic [31:0]   D_Instr;
    logic [CW-1:0] count;

    modport master (
        output F_PC, F_Instr, F_valid, D_flush, D_ready,
        input  F_ready, D_valid, D_PC, D_Instr, count
    );

    modport slave (
        input  F_PC, F_Instr, F_valid, D_flush, D_ready,
        output F_ready, D_valid, D_PC, D_Instr, count
    );

endinterface

// File: rtl/fd_fq_storage.sv
// DEPTH-entry {PC, Instr} register array: one write port, one async read port.
module fd_fq_storage
    import fd_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: PC_RESET, instr: INSTR_NOP};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fd_fetch_queue.sv
// Fetch-to-decode instruction FIFO with redirect flush.
// Define FD_FQ_BYPASS_EN for a zero-latency path through an empty queue.
module fd_fetch_queue
    import fd_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    fd_fetch_queue_if.slave q
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [CW-1:0] cnt;
    fq_entry_t     head;
    fq_entry_t     wdata;
    logic          empty;
    logic          full;
    logic          byp;
    logic          take;
    logic          push;
    logic          pop;
    logic          we;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

`ifdef FD_FQ_BYPASS_EN
    assign byp = empty & ~q.D_flush;
`else
    assign byp = 1'b0;
`endif

    assign q.F_ready = ~full;
    assign q.D_valid = byp ? q.F_valid : ~empty;
    assign q.D_PC    = byp ? q.F_PC : head.pc;
    assign q.count   = cnt;

    always_comb begin
        q.D_Instr = head.instr;
        if (byp) begin
            q.D_Instr = q.F_Instr;
        end else if (empty) begin
            q.D_Instr = INSTR_NOP;
        end
    end

    // A bypassed word consumed straight through never touches storage.
    assign take  = byp & q.F_valid & q.D_ready;
    assign push  = q.F_valid & q.F_ready & ~take;
    assign pop   = q.D_valid & q.D_ready & ~take;
    assign we    = push & ~q.D_flush;
    assign wdata = '{pc: q.F_PC, instr: q.F_Instr};

    fd_fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wr),
        .wdata (wdata),
        .raddr (rd),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (q.D_flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop)  rd <= rd + AW'(1);
            unique case (1'b1)
                push & ~pop: cnt <= cnt + CW'(1);
                pop & ~push: cnt <= cnt - CW'(1);
                default:     cnt <= cnt;
            endcase
        end
    end

endmodule
